// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op codes, op legality and FSM states.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_LUI = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // 3'b100 and 3'b101 have no ALU function behind them.
    function automatic logic is_legal_op(input logic [2:0] op);
        logic legal;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_LUI, OP_SUB, OP_SLT: legal = 1'b1;
            default:                                     legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Round-robin picker: first valid requester at or after the pointer, with wrap.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o
);

    logic found;
    int   j;

    // Scan NREQ slots starting at the pointer; the first valid slot wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && valid_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters. A transaction walks
// IDLE (grant + latch) -> EXEC (ALU evaluates latched operands) -> RESP
// (registered result held until accepted).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [3*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_zero,
    output logic                  rsp_err,
    output logic [WIDTH-1:0]      alu_reg1,
    output logic [WIDTH-1:0]      alu_reg2,
    output logic [2:0]            alu_op,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic                  alu_zero,
    output logic                  busy
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic [NREQ-1:0]  pick_grant;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;
    logic             accept;
    logic [2:0]       op_sel;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    assign pick_any = |pick_grant;
    // Valid is held until ready, so a grant in IDLE is the handshake.
    assign accept   = (state_q == IDLE) && pick_any;

    // Ready only while idle; suppressed while reset is held so nothing
    // appears to be accepted during reset.
    assign req_ready  = (state_q == IDLE && !reset) ? pick_grant : '0;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;
    assign alu_reg1   = a_q;
    assign alu_reg2   = b_q;
    assign alu_op     = op_q;
    assign busy       = (state_q != IDLE);

    // Select the winning requester's payload slice.
    always_comb begin
        op_sel = '0;
        a_sel  = '0;
        b_sel  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDW'(i)) begin
                op_sel = req_op[3*i +: 3];
                a_sel  = req_a[WIDTH*i +: WIDTH];
                b_sel  = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    // Next-state logic for the transaction FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the latched request, captured response and pointer.
    always_comb begin
        ptr_d  = ptr_q;
        id_d   = id_q;
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        res_d  = res_q;
        zero_d = zero_q;
        err_d  = err_q;
        if (accept) begin
            id_d = pick_idx;
            op_d = op_sel;
            a_d  = a_sel;
            b_d  = b_sel;
        end
        if (state_q == EXEC) begin
            if (is_legal_op(op_q)) begin
                res_d  = alu_result;
                zero_d = alu_zero;
                err_d  = 1'b0;
            end else begin
                res_d  = '0;
                zero_d = 1'b0;
                err_d  = 1'b1;
            end
        end
        if (state_q == RESP && rsp_ready) begin
            // The requester just served drops to lowest priority.
            ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request, response and pointer registers; reset drops any in-flight work.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q  <= '0;
            id_q   <= '0;
            op_q   <= 3'b000;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            zero_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            id_q   <= id_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            res_q  <= res_d;
            zero_q <= zero_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W   = 32;
    localparam int N   = 2;
    localparam int IDW = 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [3*N-1:0]   req_op = '0;
    logic [W*N-1:0]   req_a = '0;
    logic [W*N-1:0]   req_b = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [IDW-1:0]   rsp_id;
    logic [W-1:0]     rsp_result;
    logic             rsp_zero;
    logic             rsp_err;
    logic [W-1:0]     alu_reg1;
    logic [W-1:0]     alu_reg2;
    logic [2:0]       alu_op;
    logic [W-1:0]     alu_result;
    logic             alu_zero;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .alu_reg1   (alu_reg1),
        .alu_reg2   (alu_reg2),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .busy       (busy)
    );

    // Stand-in for the shared ALU; illegal codes yield junk the arbiter must mask.
    always_comb begin
        alu_zero = 1'b1;
        case (alu_op)
            3'b000:  alu_result = alu_reg1 & alu_reg2;
            3'b001:  alu_result = alu_reg1 | alu_reg2;
            3'b010:  alu_result = alu_reg1 + alu_reg2;
            3'b110:  alu_result = alu_reg1 - alu_reg2;
            3'b011:  alu_result = {alu_reg2[15:0], 16'h0000};
            3'b111:  alu_result = (alu_reg1 < alu_reg2) ? 32'd1 : 32'd0;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
        if (alu_op != 3'b100 && alu_op != 3'b101) alu_zero = (alu_result == 0);
    end

    // Expected {err, zero, result} for a request, straight from the op table.
    function automatic logic [W+1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: r = a + b;
            3'b110: r = a - b;
            3'b011: r = b << 16;
            3'b111: r = (a < b) ? 1 : 0;
            default: return {1'b1, 1'b0, {W{1'b0}}};
        endcase
        return {1'b0, (r == 0), r};
    endfunction

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic set_req(input int i, input logic v, input logic [2:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[i]     = v;
        req_op[3*i +: 3] = op;
        req_a[W*i +: W]  = a;
        req_b[W*i +: W]  = b;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        set_req(0, 1'b1, OP_ADD, 32'd1, 32'd2);
        set_req(1, 1'b1, OP_OR, 32'd3, 32'd4);
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if ({rsp_valid, busy, req_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got valid/busy/ready %b want 0000", {rsp_valid, busy, req_ready});
        end
        n_checks++;
        if ({rsp_id, rsp_result, rsp_zero, rsp_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_rsp: got id %0d res %h z %b e %b want all 0", rsp_id, rsp_result, rsp_zero, rsp_err);
        end
        n_checks++;
        if ({alu_reg1, alu_reg2, alu_op} !== '0) begin
            n_fail++;
            $display("FAIL reset_alu: got %h %h %b want 0", alu_reg1, alu_reg2, alu_op);
        end
        req_valid = '0;
        reset = 1'b0;
    endtask

    task automatic test_single_add();
        @(negedge clk);
        rsp_ready = 1'b1;
        set_req(0, 1'b1, OP_ADD, 32'd5, 32'd7);
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL add_ready: got %b want 01", req_ready);
        end
        @(negedge clk);
        set_req(0, 1'b0, OP_ADD, 32'd5, 32'd7);
        #1;
        n_checks++;
        if ({busy, rsp_valid, req_ready} !== 4'b1000) begin
            n_fail++; $display("FAIL add_exec: got busy/valid/ready %b want 1000", {busy, rsp_valid, req_ready});
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err} !== {1'b1, 1'b0, 32'd12, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL add_rsp: got v%b id%0d res %h z%b e%b want v1 id0 res 0000000c z0 e0",
                               rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({busy, rsp_valid} !== 2'b00) begin
            n_fail++; $display("FAIL add_done: got busy/valid %b want 00", {busy, rsp_valid});
        end
    endtask

    task automatic test_both_valid();
        apply_reset();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, OP_AND, 32'hF0, 32'h0F);
        set_req(1, 1'b1, OP_SUB, 32'd3, 32'd3);
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL both_grant0: got %b want 01", req_ready);
        end
        @(negedge clk);
        set_req(0, 1'b0, OP_AND, 32'hF0, 32'h0F);
        #1;
        n_checks++;
        if (req_ready !== 2'b00) begin
            n_fail++; $display("FAIL both_exec_ready: got %b want 00", req_ready);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err} !== {1'b1, 1'b0, 32'd0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL both_rsp0: got v%b id%0d res %h z%b e%b want v1 id0 res 0 z1 e0",
                               rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (req_ready !== 2'b10) begin
            n_fail++; $display("FAIL both_grant1: got %b want 10", req_ready);
        end
        @(negedge clk);
        set_req(1, 1'b0, OP_SUB, 32'd3, 32'd3);
        @(negedge clk);
        #1;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err} !== {1'b1, 1'b1, 32'd0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL both_rsp1: got v%b id%0d res %h z%b e%b want v1 id1 res 0 z1 e0",
                               rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(1, 1'b1, OP_SLT, 32'd3, 32'd5);
        #1;
        n_checks++;
        if (req_ready !== 2'b10) begin
            n_fail++; $display("FAIL bp_grant: got %b want 10", req_ready);
        end
        @(negedge clk);
        set_req(1, 1'b0, OP_SLT, 32'd3, 32'd5);
        set_req(0, 1'b1, OP_OR, 32'hA, 32'h5);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, req_ready} !==
                {1'b1, 1'b1, 32'd1, 1'b0, 1'b0, 2'b00}) begin
                n_fail++; $display("FAIL bp_hold%0d: got v%b id%0d res %h z%b e%b rdy %b want v1 id1 res 1 z0 e0 rdy 00",
                                   k, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if ({rsp_valid, busy, req_ready} !== 4'b0001) begin
            n_fail++; $display("FAIL bp_release: got valid/busy/ready %b want 0001", {rsp_valid, busy, req_ready});
        end
        set_req(0, 1'b0, OP_OR, 32'hA, 32'h5);
    endtask

    task automatic test_illegal_lui();
        logic [2:0] ops [2];
        logic [W-1:0] want [2];
        logic errs [2];
        ops[0] = 3'b100; want[0] = 32'd0;         errs[0] = 1'b1;
        ops[1] = OP_LUI; want[1] = 32'h1234_0000; errs[1] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            rsp_ready = 1'b1;
            set_req(0, 1'b1, ops[t], (t == 0) ? 32'd1 : 32'hCAFE_0001, (t == 0) ? 32'd1 : 32'h0000_1234);
            @(negedge clk);
            set_req(0, 1'b0, ops[t], 32'd0, 32'd0);
            @(negedge clk);
            #1;
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err} !== {1'b1, 1'b0, want[t], 1'b0, errs[t]}) begin
                n_fail++; $display("FAIL illegal_lui%0d: got v%b id%0d res %h z%b e%b want v1 id0 res %h z0 e%b",
                                   t, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, want[t], errs[t]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_exec();
        @(negedge clk);
        rsp_ready = 1'b1;
        set_req(0, 1'b1, OP_ADD, 32'd100, 32'd200);
        @(negedge clk);
        set_req(0, 1'b0, OP_ADD, 32'd100, 32'd200);
        set_req(1, 1'b1, OP_ADD, 32'd1, 32'd1);
        #1;
        n_checks++;
        if ({busy, req_ready} !== 3'b100) begin
            n_fail++; $display("FAIL rexec_pre: got busy/ready %b want 100", {busy, req_ready});
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({rsp_valid, busy, req_ready} !== 4'b0000) begin
            n_fail++; $display("FAIL rexec_async: got valid/busy/ready %b want 0000", {rsp_valid, busy, req_ready});
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({rsp_valid, busy, req_ready} !== 4'b0000) begin
            n_fail++; $display("FAIL rexec_hold: got valid/busy/ready %b want 0000", {rsp_valid, busy, req_ready});
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({rsp_valid, req_ready} !== 3'b010) begin
            n_fail++; $display("FAIL rexec_regrant: got valid/ready %b want 010", {rsp_valid, req_ready});
        end
        @(negedge clk);
        set_req(1, 1'b0, OP_ADD, 32'd1, 32'd1);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rexec_noresp: got valid %b want 0", rsp_valid);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err} !== {1'b1, 1'b1, 32'd2, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL rexec_rsp: got v%b id%0d res %h z%b e%b want v1 id1 res 2 z0 e0",
                               rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err);
        end
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int n_acc, n_rsp, last_acc;
        logic [W-1:0] want;
        n_acc = 0; n_rsp = 0; last_acc = 0;
        apply_reset();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, OP_ADD, 32'd10, 32'd20);
        set_req(1, 1'b1, OP_SUB, 32'd9, 32'd4);
        for (int c = 0; c < 40 && n_rsp < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (req_ready != 2'b00) begin
                n_checks++;
                if (req_ready !== ((n_acc % 2 == 0) ? 2'b01 : 2'b10)) begin
                    n_fail++; $display("FAIL fair_grant%0d: got %b want %b", n_acc, req_ready,
                                       (n_acc % 2 == 0) ? 2'b01 : 2'b10);
                end
                if (n_acc > 0) begin
                    n_checks++;
                    if (c - last_acc != 3) begin
                        n_fail++; $display("FAIL fair_spacing%0d: got %0d cycles want 3", n_acc, c - last_acc);
                    end
                end
                last_acc = c;
                n_acc++;
            end
            if (rsp_valid === 1'b1) begin
                want = (n_rsp % 2 == 0) ? 32'd30 : 32'd5;
                n_checks++;
                if ({rsp_id, rsp_result, rsp_err} !== {1'(n_rsp % 2), want, 1'b0}) begin
                    n_fail++; $display("FAIL fair_rsp%0d: got id%0d res %h e%b want id%0d res %h e0",
                                       n_rsp, rsp_id, rsp_result, rsp_err, n_rsp % 2, want);
                end
                n_rsp++;
            end
        end
        req_valid = '0;
        n_checks++;
        if (n_rsp != 8) begin
            n_fail++; $display("FAIL fair_count: got %0d responses want 8", n_rsp);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_random();
        logic         pv  [N];
        logic [2:0]   pop [N];
        logic [W-1:0] pa  [N];
        logic [W-1:0] pb  [N];
        logic [W+1:0] cexp;
        logic [IDW-1:0] cid;
        logic [N-1:0] er;
        bit   active;
        int   mptr, ca, w, j, n_acc, n_rsp;
        apply_reset();
        mptr = 0; active = 0; ca = 0; cid = '0; cexp = '0; n_acc = 0; n_rsp = 0;
        for (int i = 0; i < N; i++) begin
            pv[i] = 1'b0; pop[i] = '0; pa[i] = '0; pb[i] = '0;
        end
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && c < 460 && $urandom_range(0, 2) == 0) begin
                    pv[i]  = 1'b1;
                    pop[i] = 3'($urandom_range(0, 7));
                    pa[i]  = rand_opnd();
                    pb[i]  = ($urandom_range(0, 3) == 0) ? pa[i] : rand_opnd();
                end
                set_req(i, pv[i], pop[i], pa[i], pb[i]);
            end
            rsp_ready = (c >= 460) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            n_checks++;
            if (busy !== active) begin
                n_fail++; $display("FAIL rand_busy@%0d: got %b want %b", c, busy, active);
            end
            if (!active) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    j = (mptr + k) % N;
                    if (w < 0 && pv[j]) w = j;
                end
                er = (w < 0) ? '0 : N'(1) << w;
                n_checks++;
                if (req_ready !== er) begin
                    n_fail++; $display("FAIL rand_ready@%0d: got %b want %b", c, req_ready, er);
                end
                if (w >= 0) begin
                    active = 1; ca = c; cid = IDW'(w);
                    cexp = ref_alu(pop[w], pa[w], pb[w]);
                    pv[w] = 1'b0;
                    n_acc++;
                end
            end else begin
                n_checks++;
                if ({req_ready, rsp_valid} !== {2'b00, (c >= ca + 2)}) begin
                    n_fail++; $display("FAIL rand_phase@%0d: got ready %b valid %b want 00 %b",
                                       c, req_ready, rsp_valid, (c >= ca + 2));
                end
                if (c >= ca + 2) begin
                    n_checks++;
                    if ({rsp_id, rsp_err, rsp_zero, rsp_result} !== {cid, cexp}) begin
                        n_fail++; $display("FAIL rand_rsp@%0d: got id%0d e%b z%b res %h want id%0d e%b z%b res %h",
                                           c, rsp_id, rsp_err, rsp_zero, rsp_result,
                                           cid, cexp[W+1], cexp[W], cexp[W-1:0]);
                    end
                    if (rsp_ready) begin
                        active = 0;
                        mptr = (int'(cid) + 1) % N;
                        n_rsp++;
                    end
                end
            end
        end
        req_valid = '0;
        n_checks++;
        if (n_rsp != n_acc || n_acc < 20) begin
            n_fail++; $display("FAIL rand_count: got %0d responses for %0d accepts", n_rsp, n_acc);
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_both_valid();
        test_backpressure();
        test_illegal_lui();
        test_reset_exec();
        test_fairness();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
